// File: rtl/cv32e41p_pkg.sv
// Shared definitions for the cv32e41p write-back queue and its forwarding match logic.
package cv32e41p_pkg;

  localparam int WBQ_ADDR_WIDTH    = 6;
  localparam int WBQ_DATA_WIDTH    = 32;
  localparam int WBQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [WBQ_ADDR_WIDTH-1:0] addr;
    logic [WBQ_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cv32e41p_wb_fwd_match.sv
// Youngest-match search over the write-back queue for a single register-file read address.
module cv32e41p_wb_fwd_match
  import cv32e41p_pkg::*;
#(
  parameter int ADDR_WIDTH = WBQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = WBQ_DATA_WIDTH,
  parameter int DEPTH      = WBQ_DEPTH_DEFAULT,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  en_reg_zero_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [ADDR_WIDTH-1:0] entry_addr_i [DEPTH],
  input  logic [DATA_WIDTH-1:0] entry_data_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PTR_W-1:0]      head_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic w_fp_bank;
  logic w_zero_reg;
  logic w_allow;
  logic [PTR_W-1:0] w_idx;
  logic w_match;

  if (ADDR_WIDTH >= 6) begin : g_fp
    assign w_fp_bank = raddr_i[5];
  end else begin : g_nofp
    assign w_fp_bank = 1'b0;
  end

  // x0 is hard-wired unless en_reg_zero makes it a real register; f0 is always real
  assign w_zero_reg = (raddr_i[4:0] == 5'd0) && !w_fp_bank;
  assign w_allow    = en_reg_zero_i || !w_zero_reg;

  // Walk oldest to youngest so the last match written is the youngest one
  always_comb begin
    hit_o   = 1'b0;
    data_o  = {DATA_WIDTH{1'b0}};
    w_idx   = head_i;
    w_match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx   = head_i + PTR_W'(k);
      w_match = w_allow && valid_i[w_idx] && (entry_addr_i[w_idx] == raddr_i);
      hit_o   = hit_o | w_match;
      data_o  = w_match ? entry_data_i[w_idx] : data_o;
    end
  end

endmodule

// File: rtl/cv32e41p_wb_queue.sv
// In-order load write-back queue feeding register-file port B, with youngest-entry
// forwarding to the three decode read ports.
module cv32e41p_wb_queue
  import cv32e41p_pkg::*;
#(
  parameter int ADDR_WIDTH = WBQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = WBQ_DATA_WIDTH,
  parameter int DEPTH      = WBQ_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_reg_zero,
  input  logic                       lsu_valid_i,
  output logic                       lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]      lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
  input  logic                       drain_en_i,
  output logic                       we_b_o,
  output logic [ADDR_WIDTH-1:0]      waddr_b_o,
  output logic [DATA_WIDTH-1:0]      wdata_b_o,
  input  logic [ADDR_WIDTH-1:0]      raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_c_i,
  output logic                       fwd_hit_a_o,
  output logic                       fwd_hit_b_o,
  output logic                       fwd_hit_c_o,
  output logic [DATA_WIDTH-1:0]      fwd_data_a_o,
  output logic [DATA_WIDTH-1:0]      fwd_data_b_o,
  output logic [DATA_WIDTH-1:0]      fwd_data_c_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid;

  assign lsu_ready_o = (r_count != FULL_CNT);
  assign w_push      = lsu_valid_i && lsu_ready_o;
  // Gated by rst so a reset cycle never leaks a queued entry into the register file
  assign w_pop       = drain_en_i && (r_count != {CNT_W{1'b0}}) && !rst;
  assign we_b_o      = w_pop;
  assign waddr_b_o   = r_addr[r_rd_ptr];
  assign wdata_b_o   = r_data[r_rd_ptr];
  assign occupancy_o = r_count;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] w_off;
    assign w_off       = PTR_W'(gi) - r_rd_ptr;
    assign w_valid[gi] = (CNT_W'(w_off) < r_count);
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= {ADDR_WIDTH{1'b0}};
        r_data[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr] <= lsu_waddr_i;
        r_data[r_wr_ptr] <= lsu_wdata_i;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  cv32e41p_wb_fwd_match #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) u_fwd_a (
    .en_reg_zero_i(en_reg_zero), .raddr_i(raddr_a_i), .entry_addr_i(r_addr),
    .entry_data_i(r_data), .valid_i(w_valid), .head_i(r_rd_ptr),
    .hit_o(fwd_hit_a_o), .data_o(fwd_data_a_o)
  );

  cv32e41p_wb_fwd_match #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) u_fwd_b (
    .en_reg_zero_i(en_reg_zero), .raddr_i(raddr_b_i), .entry_addr_i(r_addr),
    .entry_data_i(r_data), .valid_i(w_valid), .head_i(r_rd_ptr),
    .hit_o(fwd_hit_b_o), .data_o(fwd_data_b_o)
  );

  cv32e41p_wb_fwd_match #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) u_fwd_c (
    .en_reg_zero_i(en_reg_zero), .raddr_i(raddr_c_i), .entry_addr_i(r_addr),
    .entry_data_i(r_data), .valid_i(w_valid), .head_i(r_rd_ptr),
    .hit_o(fwd_hit_c_o), .data_o(fwd_data_c_o)
  );

endmodule

// File: tb/tb_cv32e41p_wb_queue.sv
// Randomized and directed checks of cv32e41p_wb_queue against a queue-based reference model.
module tb_cv32e41p_wb_queue;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_reg_zero;
  logic          lsu_valid_i;
  logic          lsu_ready_o;
  logic [AW-1:0] lsu_waddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          drain_en_i;
  logic          we_b_o;
  logic [AW-1:0] waddr_b_o;
  logic [DW-1:0] wdata_b_o;
  logic [AW-1:0] raddr_a_i, raddr_b_i, raddr_c_i;
  logic          fwd_hit_a_o, fwd_hit_b_o, fwd_hit_c_o;
  logic [DW-1:0] fwd_data_a_o, fwd_data_b_o, fwd_data_c_o;
  logic [2:0]    occupancy_o;

  int   total = 0;
  int   bad = 0;
  ent_t mq[$];

  cv32e41p_wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en_reg_zero(en_reg_zero),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .drain_en_i(drain_en_i), .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .fwd_hit_a_o(fwd_hit_a_o), .fwd_hit_b_o(fwd_hit_b_o), .fwd_hit_c_o(fwd_hit_c_o),
    .fwd_data_a_o(fwd_data_a_o), .fwd_data_b_o(fwd_data_b_o), .fwd_data_c_o(fwd_data_c_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference forwarding: youngest queued entry with the same address, x0 excluded unless enabled
  task automatic model_fwd(input logic [AW-1:0] ra, input logic ez,
                           output logic hit, output logic [DW-1:0] data);
    hit = 1'b0;
    data = '0;
    if (!ez && ra == 6'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == ra) begin
        hit = 1'b1;
        data = mq[i].d;
        return;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic dr, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rc, input logic ez);
    logic h;
    logic [DW-1:0] fd;
    int sz;
    @(negedge clk);
    lsu_valid_i = v; lsu_waddr_i = a; lsu_wdata_i = d; drain_en_i = dr;
    raddr_a_i = ra; raddr_b_i = rb; raddr_c_i = rc; en_reg_zero = ez;
    #1;
    sz = mq.size();
    chk("ready", {31'd0, lsu_ready_o}, {31'd0, sz != DEPTH});
    chk("we_b", {31'd0, we_b_o}, {31'd0, dr && sz != 0});
    chk("occupancy", {29'd0, occupancy_o}, sz);
    if (sz != 0) begin
      chk("waddr_b", {26'd0, waddr_b_o}, {26'd0, mq[0].a});
      chk("wdata_b", wdata_b_o, mq[0].d);
    end
    model_fwd(ra, ez, h, fd);
    chk("hit_a", {31'd0, fwd_hit_a_o}, {31'd0, h});
    chk("data_a", fwd_data_a_o, fd);
    model_fwd(rb, ez, h, fd);
    chk("hit_b", {31'd0, fwd_hit_b_o}, {31'd0, h});
    chk("data_b", fwd_data_b_o, fd);
    model_fwd(rc, ez, h, fd);
    chk("hit_c", {31'd0, fwd_hit_c_o}, {31'd0, h});
    chk("data_c", fwd_data_c_o, fd);
    @(posedge clk);
    if (dr && sz != 0) void'(mq.pop_front());
    if (v && sz != DEPTH) mq.push_back('{a: a, d: d});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; lsu_valid_i = 1'b1; drain_en_i = 1'b1;
    lsu_waddr_i = 6'd9; lsu_wdata_i = 32'hBAD0BAD0;
    #1;
    chk("we_b_in_reset", {31'd0, we_b_o}, 32'd0);
    repeat (n) @(posedge clk);
    mq.delete();
    @(negedge clk);
    rst = 1'b0; lsu_valid_i = 1'b0; drain_en_i = 1'b0;
    raddr_a_i = 6'd9; raddr_b_i = 6'd0; raddr_c_i = 6'd32; en_reg_zero = 1'b1;
    #1;
    chk("rst_occ", {29'd0, occupancy_o}, 32'd0);
    chk("rst_ready", {31'd0, lsu_ready_o}, 32'd1);
    chk("rst_we_b", {31'd0, we_b_o}, 32'd0);
    chk("rst_waddr", {26'd0, waddr_b_o}, 32'd0);
    chk("rst_wdata", wdata_b_o, 32'd0);
    chk("rst_hits", {29'd0, fwd_hit_a_o, fwd_hit_b_o, fwd_hit_c_o}, 32'd0);
    chk("rst_fdata", fwd_data_a_o | fwd_data_b_o | fwd_data_c_o, 32'd0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] tbl [6];
    tbl = '{6'd0, 6'd5, 6'd7, 6'd32, 6'd33, 6'd7};
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return tbl[$urandom_range(0, 5)];
  endfunction

  initial begin
    rst = 1'b1; en_reg_zero = 1'b0; lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
    drain_en_i = 1'b0; raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
    do_reset(2);

    // Pass-through: visible on port B one cycle after the push, then gone
    cycle(1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 6'd5, 6'd0, 6'd0, 1'b0);
    cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 6'd0, 6'd0, 1'b0);
    cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 6'd0, 6'd0, 1'b0);

    // Fill to full, one refused push, then drain in order
    for (int i = 0; i < 5; i++)
      cycle(1'b1, AW'(i + 1), 32'h100 + i, 1'b0, 6'd3, 6'd1, 6'd4, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 6'd1, 6'd5, 1'b0);

    // Forwarding priority on a repeated destination
    cycle(1'b1, 6'd7, 32'h11, 1'b0, 6'd7, 6'd0, 6'd0, 1'b0);
    cycle(1'b1, 6'd7, 32'h22, 1'b0, 6'd7, 6'd0, 6'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 6'd7, 6'd0, 1'b0);

    // x0 versus f0
    cycle(1'b1, 6'd0, 32'h55, 1'b0, 6'd0, 6'd0, 6'd32, 1'b0);
    cycle(1'b1, 6'd32, 32'h66, 1'b0, 6'd0, 6'd0, 6'd32, 1'b0);
    cycle(1'b0, 6'd0, 32'd0, 1'b0, 6'd32, 6'd0, 6'd32, 1'b0);
    cycle(1'b0, 6'd0, 32'd0, 1'b0, 6'd32, 6'd0, 6'd32, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd0, 6'd0, 6'd32, 1'b1);

    // Full with simultaneous push and pop, then reset with entries still queued
    for (int i = 0; i < 4; i++)
      cycle(1'b1, AW'(i + 10), 32'hA0 + i, 1'b0, 6'd10, 6'd11, 6'd13, 1'b0);
    cycle(1'b1, 6'd20, 32'hEE, 1'b1, 6'd20, 6'd11, 6'd13, 1'b0);
    cycle(1'b0, 6'd0, 32'd0, 1'b0, 6'd20, 6'd11, 6'd13, 1'b0);
    do_reset(1);
    cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd11, 6'd12, 6'd13, 1'b0);

    // Randomized traffic with varying drain pressure
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, pick_addr(), $urandom,
            $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 80),
            pick_addr(), pick_addr(), pick_addr(), $urandom_range(0, 1) == 1);
      if (i == 300) do_reset(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e41p_wb_queue.md
Name: cv32e41p_wb_queue

Overview:
Write-back queue between the LSU load-return path and write port B of the integer/FP register file. It buffers up to DEPTH completed load results and drains them in order into port B when the controller allows it. It also provides youngest-entry operand forwarding to the three register-file read ports, so decode sees values that are queued but not yet written.

Parameters:
ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank (FPU=1, ZFINX=0 builds).
DATA_WIDTH, 32, write data width.
DEPTH, 4, queue entries; power of two, ≥2.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
en_reg_zero  input  1  when high, x0 is an ordinary register for forwarding purposes
lsu_valid_i  input  1  load result valid
lsu_ready_o  output  1  queue can accept an entry
lsu_waddr_i  input  ADDR_WIDTH  destination register
lsu_wdata_i  input  DATA_WIDTH  load result
drain_en_i  input  1  controller permits a write on port B this cycle
we_b_o  output  1  to register-file we_b_i
waddr_b_o  output  ADDR_WIDTH  to register-file waddr_b_i
wdata_b_o  output  DATA_WIDTH  to register-file wdata_b_i
raddr_a_i, raddr_b_i, raddr_c_i  input  ADDR_WIDTH each  decode read addresses, same as the register-file read ports
fwd_hit_a_o, fwd_hit_b_o, fwd_hit_c_o  output  1 each  a queued entry matches the read address
fwd_data_a_o, fwd_data_b_o, fwd_data_c_o  output  DATA_WIDTH each  data of the youngest matching entry
occupancy_o  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Storage is a circular buffer: DEPTH entries of {addr, data}, plus wr_ptr, rd_ptr and count registers. Pointers wrap modulo DEPTH.
- Reset, synchronous on clk with rst=1:
  - count, wr_ptr and rd_ptr go to 0; all entries clear to 0.
  - After reset: lsu_ready_o=1, we_b_o=0, waddr_b_o=0, wdata_b_o=0, all fwd_hit=0, all fwd_data=0, occupancy_o=0.
  - A reset mid-operation discards all queued entries; none are written to the register file.
- Push: lsu_ready_o = (count != DEPTH), registered-state only, with no combinational path from the inputs. On lsu_valid_i && lsu_ready_o, the entry is written at wr_ptr and wr_ptr increments.
- Pop: we_b_o = drain_en_i && (count != 0). waddr_b_o and wdata_b_o always show the head entry at rd_ptr. When we_b_o=1, rd_ptr increments at the clock edge.
- Latency: an entry pushed in cycle N drives we_b_o no earlier than cycle N+1. There is no empty-queue bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, the push is refused even if a pop happens in the same cycle.
- count updates +1 on push only, −1 on pop only, unchanged on both or neither. occupancy_o = count.
- Ordering is strict FIFO. Multiple entries may target the same register; the last one written wins in the register file.
- Forwarding, combinational, evaluated independently per read port:
  - Scan the valid entries from youngest (wr_ptr−1) to oldest (rd_ptr).
  - fwd_hit = 1 if any entry's addr equals raddr. fwd_data = data of the youngest matching entry; 0 when there is no hit.
  - The entry draining in the current cycle still forwards, which keeps the view consistent with the register file one cycle later.
  - An address with bits[4:0]==0 and (ADDR_WIDTH<6 or bit5==0) never hits while en_reg_zero=0. Such entries are still queued and drained.
  - FP-bank addresses (bit5=1) match only on the full ADDR_WIDTH address.
- Invalid slots never produce a hit, regardless of stale contents.

Decomposition:
- Shared package cv32e41p_pkg gets:
  - typedef wb_entry_t {logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data;}
  - constant WBQ_DEPTH_DEFAULT=4.
- One sub-module, cv32e41p_wb_fwd_match: combinational youngest-match search over the entry array, valid mask and head pointer for one read address. It is instantiated three times.

Test Plan:
- Reset: assert rst 2 cycles with lsu_valid_i=1 → after release, occupancy_o=0, lsu_ready_o=1, we_b_o=0, all fwd_hit=0.
- Pass-through: drain_en_i=1; push {addr 5, 0xDEADBEEF} in cycle N → we_b_o=1, waddr_b_o=5, wdata_b_o=0xDEADBEEF in cycle N+1; occupancy 0 by cycle N+2.
- Fill/stall: drain_en_i=0; push 4 entries → occupancy_o=4 and lsu_ready_o=0; a fifth push is ignored. Then drain_en_i=1 → four we_b_o pulses in push order.
- Forwarding priority: queue {x7,0x11}, {x7,0x22}; raddr_a=7 → fwd_hit_a=1, data 0x22. After the first pop, data is still 0x22; after the second pop, fwd_hit_a=0.
- x0 and FP bank: queue {x0,0x55} and {f0 (addr 32),0x66}. With en_reg_zero=0, raddr_b=0 → no hit and raddr_c=32 → hit with 0x66. With en_reg_zero=1, raddr_b=0 → hit with 0x55.
- Full with pop, then mid-reset: at count=4 with push and pop in the same cycle → count=3 and the push is refused. Assert rst with 3 entries queued → no further we_b_o, occupancy_o=0.
